// File: rtl/mux_scan_ctrl.sv
// Scan controller for a 4:1 mux: steps the selects, samples each channel
// after a settle dwell, and hands complete 4-bit frames to a consumer.
module mux_scan_ctrl #(
   parameter int DWELL_W = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               enable,
   input  logic [DWELL_W-1:0] dwell,
   input  logic               mux_out,
   input  logic               frame_ready,
   output logic               s0,
   output logic               s1,
   output logic [3:0]         frame,
   output logic               frame_valid,
   output logic               overrun,
   output logic               busy
);

   typedef enum logic {IDLE, SCAN} state_t;

   state_t             state_q, state_d;
   logic [1:0]         sel_q, sel_d;
   logic [DWELL_W-1:0] count_q, count_d;
   logic [DWELL_W-1:0] dwell_q, dwell_d;
   logic [3:0]         shift_q, shift_d;
   logic [3:0]         frame_d;
   logic               fv_d, ov_d, busy_d;
   logic               last;
   logic [3:0]         assembled;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (enable)  state_d = SCAN;
         SCAN: if (!enable) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // ch d is sampled on the completing edge, so it bypasses the shift bits
   assign last      = (state_q == SCAN) && (count_q == '0) && (sel_q == 2'd3);
   assign assembled = {mux_out, shift_q[2:0]};

   always_comb begin
      sel_d   = sel_q;
      count_d = count_q;
      dwell_d = dwell_q;
      shift_d = shift_q;
      frame_d = frame;
      fv_d    = frame_valid;
      ov_d    = overrun;
      unique case (state_q)
         IDLE: begin
            sel_d   = 2'd0;
            count_d = '0;
            if (enable) begin
               dwell_d = dwell;
               count_d = dwell;
            end
         end
         SCAN: begin
            if (count_q != '0) begin
               count_d = count_q - 1'b1;
            end else begin
               shift_d[sel_q] = mux_out;
               if (sel_q != 2'd3) begin
                  sel_d   = sel_q + 2'd1;
                  count_d = dwell_q;
               end else begin
                  sel_d   = 2'd0;
                  dwell_d = dwell;
                  count_d = dwell;
               end
            end
            if (!enable) begin
               sel_d   = 2'd0;
               count_d = '0;
               shift_d = 4'd0;
               ov_d    = 1'b0;
            end
         end
         default: ;
      endcase
      if (last && (!frame_valid || frame_ready)) begin
         frame_d = assembled;
         fv_d    = 1'b1;
      end else if (last) begin
         ov_d = 1'b1;
      end else if (frame_valid && frame_ready) begin
         fv_d = 1'b0;
      end
      busy_d = (state_d == SCAN);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel_q       <= 2'd0;
         count_q     <= '0;
         dwell_q     <= '0;
         shift_q     <= 4'd0;
         frame       <= 4'd0;
         frame_valid <= 1'b0;
         overrun     <= 1'b0;
         busy        <= 1'b0;
      end else begin
         sel_q       <= sel_d;
         count_q     <= count_d;
         dwell_q     <= dwell_d;
         shift_q     <= shift_d;
         frame       <= frame_d;
         frame_valid <= fv_d;
         overrun     <= ov_d;
         busy        <= busy_d;
      end
   end

   assign s0 = sel_q[0];
   assign s1 = sel_q[1];

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl: a channel table drives mux_out from
// the selects; expected selects/frames are hand-derived per cycle.
module tb_mux_scan_ctrl;

   localparam int DW = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          enable = 1'b0;
   logic [DW-1:0] dwell = '0;
   logic          frame_ready = 1'b0;
   logic          mux_out;
   logic          s0, s1, frame_valid, overrun, busy;
   logic [3:0]    frame;
   logic [3:0]    chan = 4'd0;
   logic          glitch = 1'b0;
   int            total = 0;
   int            bad = 0;

   always #5 clk = ~clk;

   // channel a=bit0 .. d=bit3; glitch inverts the settling value
   assign mux_out = chan[{s1, s0}] ^ glitch;

   mux_scan_ctrl #(.DWELL_W(DW)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .dwell(dwell),
      .mux_out(mux_out), .frame_ready(frame_ready),
      .s0(s0), .s1(s1), .frame(frame), .frame_valid(frame_valid),
      .overrun(overrun), .busy(busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      // reset
      #1 rst_n = 1'b0;
      #2;
      chk("rst_sel", {30'd0, s1, s0}, 0);
      chk("rst_frame", {28'd0, frame}, 0);
      chk("rst_fv", {31'd0, frame_valid}, 0);
      chk("rst_ov", {31'd0, overrun}, 0);
      chk("rst_busy", {31'd0, busy}, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_busy", {31'd0, busy}, 0);

      // dwell=0 back-to-back frames
      chan = 4'b1101; frame_ready = 1'b1; dwell = 0; enable = 1'b1;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         chk("d0_sel", {30'd0, s1, s0}, i % 4);
         chk("d0_fv", {31'd0, frame_valid}, (i >= 4 && i % 4 == 0));
         chk("d0_busy", {31'd0, busy}, 1);
         if (i == 4 || i == 8 || i == 12)
            chk("d0_frame", {28'd0, frame}, 4'b1101);
      end
      // now in channel c: drop enable
      enable = 1'b0;
      @(negedge clk);
      chk("off_busy", {31'd0, busy}, 0);
      chk("off_sel", {30'd0, s1, s0}, 0);
      chk("off_fv", {31'd0, frame_valid}, 0);
      chk("off_ov", {31'd0, overrun}, 0);
      repeat (3) @(negedge clk);
      chk("off_fv2", {31'd0, frame_valid}, 0);

      // dwell=3 with glitches on non-sampling cycles, dwell wiggled mid-frame
      chan = 4'b0110; dwell = 3; enable = 1'b1;
      for (int i = 0; i <= 32; i++) begin
         @(negedge clk);
         chk("d3_sel", {30'd0, s1, s0}, (i / 4) % 4);
         chk("d3_fv", {31'd0, frame_valid}, (i == 16 || i == 32));
         if (i == 16 || i == 32)
            chk("d3_frame", {28'd0, frame}, 4'b0110);
         glitch = (i % 4 != 3);
         if (i == 20) dwell = 0;
         if (i == 31) dwell = 3;
      end
      glitch = 1'b0; frame_ready = 1'b0; chan = 4'b0011;

      // held frame, then completion coincident with acceptance
      for (int i = 33; i <= 48; i++) begin
         @(negedge clk);
         chk("hold_sel", {30'd0, s1, s0}, (i / 4) % 4);
         if (i == 47) begin
            chk("hold_frame", {28'd0, frame}, 4'b0110);
            chk("hold_fv", {31'd0, frame_valid}, 1);
            frame_ready = 1'b1;
         end
      end
      chk("coin_frame", {28'd0, frame}, 4'b0011);
      chk("coin_fv", {31'd0, frame_valid}, 1);
      chk("coin_ov", {31'd0, overrun}, 0);
      frame_ready = 1'b0; chan = 4'b1001;

      // two dropped completions
      for (int i = 49; i <= 80; i++) begin
         @(negedge clk);
         chk("ovr_sel", {30'd0, s1, s0}, (i / 4) % 4);
         if (i == 63) chk("ovr_pre", {31'd0, overrun}, 0);
         if (i == 64 || i == 80) begin
            chk("ovr_set", {31'd0, overrun}, 1);
            chk("ovr_frame", {28'd0, frame}, 4'b0011);
            chk("ovr_fv", {31'd0, frame_valid}, 1);
         end
      end
      frame_ready = 1'b1;
      @(negedge clk);
      chk("acc_fv", {31'd0, frame_valid}, 0);
      chk("acc_ov", {31'd0, overrun}, 1);
      chk("acc_frame", {28'd0, frame}, 4'b0011);
      for (int i = 82; i <= 89; i++) @(negedge clk);
      chk("c_sel", {30'd0, s1, s0}, 2);

      // disable during channel c clears overrun
      enable = 1'b0;
      @(negedge clk);
      chk("dis_busy", {31'd0, busy}, 0);
      chk("dis_sel", {30'd0, s1, s0}, 0);
      chk("dis_ov", {31'd0, overrun}, 0);
      chk("dis_fv", {31'd0, frame_valid}, 0);
      repeat (2) @(negedge clk);
      chk("dis_fv2", {31'd0, frame_valid}, 0);

      // fresh frame from channel a with dwell=1
      dwell = 1; chan = 4'b1010; enable = 1'b1;
      for (int j = 0; j <= 8; j++) begin
         @(negedge clk);
         chk("re_sel", {30'd0, s1, s0}, (j / 2) % 4);
         chk("re_fv", {31'd0, frame_valid}, (j == 8));
         chk("re_ov", {31'd0, overrun}, 0);
      end
      chk("re_frame", {28'd0, frame}, 4'b1010);

      // asynchronous reset between edges
      #2 rst_n = 1'b0;
      #1;
      chk("arst_fv", {31'd0, frame_valid}, 0);
      chk("arst_frame", {28'd0, frame}, 0);
      chk("arst_sel", {30'd0, s1, s0}, 0);
      chk("arst_busy", {31'd0, busy}, 0);
      chk("arst_ov", {31'd0, overrun}, 0);
      rst_n = 1'b1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mux_scan_ctrl.md
MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 Parameter DWELL_W, default 4, sets the width of the dwell input.
REQ-002 clk  input  1  Single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  Asynchronous, active-low reset.
REQ-004 enable  input  1  High = scan channels continuously; low = return to idle.
REQ-005 dwell  input  DWELL_W  Extra settle cycles per channel; each channel is selected for dwell+1 cycles.
REQ-006 mux_out  input  1  Output of the downstream 4:1 mux, sampled by this block.
REQ-007 s0  output  1  Mux select LSB (channel a=00, b=01, c=10, d=11 as {s1,s0}).
REQ-008 s1  output  1  Mux select MSB.
REQ-009 frame  output  4  Assembled sample frame; bit0=ch a, bit1=ch b, bit2=ch c, bit3=ch d.
REQ-010 frame_valid  output  1  Frame holds an unconsumed frame.
REQ-011 frame_ready  input  1  Consumer accepts frame when frame_valid && frame_ready at a rising edge.
REQ-012 overrun  output  1  Sticky flag: a completed frame was dropped.
REQ-013 busy  output  1  High while the FSM is in SCAN.

Function
REQ-014 FSM states: IDLE, SCAN; s0, s1, and busy are registered outputs.
REQ-015 IDLE: sel={s1,s0}=00, count=0; when enable=1 at an edge, go to SCAN, latch dwell into dwell_q, load count=dwell.
REQ-016 SCAN: each edge, if count!=0 then count-1; if count==0 then sample mux_out into shift bit sel (the value present before the edge).
REQ-017 SCAN, count==0, sel<3: sel+1, count reloaded from dwell_q.
REQ-018 SCAN, count==0, sel==3: frame complete; sel wraps to 00; dwell_q and count reload from the current dwell input; scanning continues.
REQ-019 Frame period = 4*(dwell+1) cycles; with dwell=0 the selects advance every cycle.
REQ-020 Frame completion, output register empty or accepted that edge (frame_valid=0 or frame_ready=1): frame <= assembled bits including the ch d sample; frame_valid=1 from the next cycle.
REQ-021 Frame completion, frame_valid=1 and frame_ready=0: new frame dropped, frame unchanged, overrun<=1.
REQ-022 Accept without completion: frame_valid<=0; frame holds its last value.
REQ-023 frame and frame_valid are never altered except per REQ-020..022; frame is stable while frame_valid=1.
REQ-024 enable=0 in SCAN: next edge to IDLE, sel=00, partial frame discarded, overrun cleared; a pending frame_valid stays until accepted.
REQ-025 enable=0 on the same edge a frame completes: the frame is still delivered per REQ-020/021, then IDLE.
REQ-026 Changes to dwell mid-frame take effect only at the next frame start.
REQ-027 overrun clears only on reset or per REQ-024; otherwise it stays set.

Reset
REQ-028 rst_n=0 immediately forces: state=IDLE, s0=0, s1=0, count=0, dwell_q=0, shift bits=0, frame=4'b0000, frame_valid=0, overrun=0, busy=0.
REQ-029 Reset asserted mid-scan or mid-handshake discards all in-flight data; there is no partial output.
REQ-030 After rst_n deasserts, the first scan starts at the first edge with enable=1.

Verification
REQ-031 dwell=0, frame_ready=1, mux_out driven per select as a=1,b=0,c=1,d=1 -> {s1,s0} sequence 00,01,10,11 one cycle each; frame=4'b1101 with frame_valid pulsing every 4 cycles.
REQ-032 dwell=3 -> each select value held 4 cycles; frame every 16 cycles; only the last-cycle sample counts (glitch mux_out on cycles 1-3 -> no effect).
REQ-033 frame_ready=0 for 2 frame periods -> first frame held unchanged, overrun=1 after the second completion; frame_ready=1 -> frame_valid drops next cycle, overrun stays 1.
REQ-034 enable dropped during channel c -> IDLE next edge, selects=00, busy=0, no frame_valid; re-enable -> fresh frame starting at channel a, overrun=0.
REQ-035 rst_n pulsed low asynchronously mid-frame with frame_valid=1 -> all outputs zero immediately, with no clock edge required.
REQ-036 Completion coincident with acceptance (frame_valid=1, frame_ready=1) -> new frame loads, frame_valid stays 1, overrun stays 0.
